edge_seq_ctrl: RTL and testbench

EDGE_SEQ_CTRL -- requirements
Module: edge_seq_ctrl

---
 rtl/edge_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_edge_seq_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_seq_ctrl.sv
// Frame sequencer for the Bayer-to-grayscale edge datapath: tracks frame phase,
// latches user mode requests at frame boundaries and aligns valid/border flags.
module edge_seq_ctrl #(
  parameter int IMG_W    = 1280,
  parameter int IMG_H    = 960,
  parameter int PIPE_LAT = 4
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iDVAL,
  input  logic [10:0] iX_Cont,
  input  logic [10:0] iY_Cont,
  input  logic        iEdgeReq,
  input  logic        iHorizReq,
  output logic        oLB_CLKEN,
  output logic        oModeEdge,
  output logic        oModeHoriz,
  output logic        oWinValid,
  output logic        oDVAL,
  output logic        oBorder,
  output logic        oFrameDone,
  output logic [7:0]  oFrameCnt,
  output logic [1:0]  oState
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    FEND = 2'd3
  } stateT;

  stateT state;

  logic                gray;
  logic [9:0]          grayX;
  logic [9:0]          grayY;
  logic                frameStart;
  logic                frameEnd;
  logic                pipeIn;
  logic                borderIn;
  logic [1:0]          edgeSync;
  logic [1:0]          horizSync;
  logic [PIPE_LAT-1:0] dvalPipe;
  logic [PIPE_LAT-1:0] borderPipe;

  // One grayscale sample per 2x2 Bayer quad, taken on its top-left pixel.
  assign gray  = iDVAL & ~iX_Cont[0] & ~iY_Cont[0];
  assign grayX = iX_Cont[10:1];
  assign grayY = iY_Cont[10:1];

  assign frameStart = iDVAL && (iX_Cont == 11'd0) && (iY_Cont == 11'd0);
  assign frameEnd   = iDVAL && (iX_Cont == 11'(IMG_W - 1)) && (iY_Cont == 11'(IMG_H - 1));

  // Samples seen while idle belong to no frame and never reach the datapath.
  assign pipeIn   = gray && ((state == FILL) || (state == RUN));
  assign borderIn = pipeIn && ((grayY < 10'd2) || (grayX < 10'd2)) && oModeEdge;

  assign oLB_CLKEN = iDVAL;
  assign oDVAL     = dvalPipe[PIPE_LAT-1];
  assign oBorder   = borderPipe[PIPE_LAT-1];
  assign oState    = state;

  // NOTE: the alignment shift register is reset like any other flop so an
  // aborted frame cannot leak stale valids into the next one.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      dvalPipe   <= '0;
      borderPipe <= '0;
      edgeSync   <= '0;
      horizSync  <= '0;
    end else begin
      dvalPipe[0]   <= pipeIn;
      borderPipe[0] <= borderIn;
      for (int i = 1; i < PIPE_LAT; i++) begin
        dvalPipe[i]   <= dvalPipe[i-1];
        borderPipe[i] <= borderPipe[i-1];
      end
      edgeSync  <= {edgeSync[0], iEdgeReq};
      horizSync <= {horizSync[0], iHorizReq};
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every branch
  // below sees the pre-edge values of state and counters.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state      <= IDLE;
      oModeEdge  <= 1'b0;
      oModeHoriz <= 1'b0;
      oWinValid  <= 1'b0;
      oFrameDone <= 1'b0;
      oFrameCnt  <= 8'd0;
    end else begin
      oFrameDone <= 1'b0;
      oWinValid  <= gray && (state == RUN) && (grayX >= 10'd2);
      unique case (state)
        IDLE: if (frameStart) state <= FILL;
        FILL: begin
          if (frameStart) state <= FILL;
          else if (gray && (grayY == 10'd2) && (grayX == 10'd0)) state <= RUN;
        end
        RUN: begin
          // A restart wins over frame end: short frames are not counted.
          if (frameStart) begin
            state <= FILL;
          end else if (frameEnd) begin
            state      <= FEND;
            oFrameDone <= 1'b1;
            oFrameCnt  <= oFrameCnt + 8'd1;
          end
        end
        FEND: begin
          state      <= IDLE;
          oModeEdge  <= edgeSync[1];
          oModeHoriz <= horizSync[1];
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_seq_ctrl.sv
// Scoreboard bench for edge_seq_ctrl on a reduced 12x10 raster: the driver queues
// expected oDVAL/oWinValid/oFrameDone events, a negedge monitor retires them.
module tb_edge_seq_ctrl;
  localparam int IMG_W    = 12;
  localparam int IMG_H    = 10;
  localparam int PIPE_LAT = 4;
  localparam int S_IDLE = 0, S_FILL = 1, S_RUN = 2, S_FEND = 3;

  logic        iCLK;
  logic        iRST;
  logic        iDVAL;
  logic [10:0] iX_Cont;
  logic [10:0] iY_Cont;
  logic        iEdgeReq;
  logic        iHorizReq;
  logic        oLB_CLKEN;
  logic        oModeEdge;
  logic        oModeHoriz;
  logic        oWinValid;
  logic        oDVAL;
  logic        oBorder;
  logic        oFrameDone;
  logic [7:0]  oFrameCnt;
  logic [1:0]  oState;

  edge_seq_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIPE_LAT(PIPE_LAT)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iX_Cont(iX_Cont), .iY_Cont(iY_Cont),
    .iEdgeReq(iEdgeReq), .iHorizReq(iHorizReq), .oLB_CLKEN(oLB_CLKEN),
    .oModeEdge(oModeEdge), .oModeHoriz(oModeHoriz), .oWinValid(oWinValid),
    .oDVAL(oDVAL), .oBorder(oBorder), .oFrameDone(oFrameDone),
    .oFrameCnt(oFrameCnt), .oState(oState)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  typedef struct { int cyc; logic border; } dvalExpT;
  typedef struct { int cyc; logic [7:0] cnt; } doneExpT;

  dvalExpT dvalQ[$];
  int      winQ[$];
  doneExpT doneQ[$];

  int         nChecks = 0;
  int         nPass = 0;
  logic       modeEdgeExp = 1'b0;
  logic [7:0] cntExp = 8'd0;

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: retires queued expectations whenever the DUT presents an event.
  always @(negedge iCLK) begin
    dvalExpT de;
    doneExpT fe;
    int      wc;
    if (!iRST) begin
      check("border_gated", int'(oBorder & ~oDVAL), 0);
      if (oDVAL) begin
        check("dval_expected", int'(dvalQ.size() > 0), 1);
        if (dvalQ.size() > 0) begin
          de = dvalQ.pop_front();
          check("dval_cycle", cyc, de.cyc);
          check("border", int'(oBorder), int'(de.border));
        end
      end
      if (oWinValid) begin
        check("win_expected", int'(winQ.size() > 0), 1);
        if (winQ.size() > 0) begin
          wc = winQ.pop_front();
          check("win_cycle", cyc, wc);
        end
      end
      if (oFrameDone) begin
        check("done_expected", int'(doneQ.size() > 0), 1);
        if (doneQ.size() > 0) begin
          fe = doneQ.pop_front();
          check("done_cycle", cyc, fe.cyc);
          check("done_cnt", int'(oFrameCnt), int'(fe.cnt));
        end
      end
    end
  end

  // Present one raw pixel; st is the hand-annotated state the DUT is in meanwhile.
  task automatic pix(input int x, input int y, input int st);
    dvalExpT de;
    doneExpT fe;
    bit      g;
    g = (x % 2 == 0) && (y % 2 == 0);
    iDVAL   = 1'b1;
    iX_Cont = 11'(x);
    iY_Cont = 11'(y);
    if (g && (st == S_FILL || st == S_RUN)) begin
      de.cyc    = cyc + PIPE_LAT;
      de.border = ((y / 2 < 2) || (x / 2 < 2)) && modeEdgeExp;
      dvalQ.push_back(de);
    end
    if (g && st == S_RUN && x / 2 >= 2) winQ.push_back(cyc + 1);
    if (st == S_RUN && x == IMG_W - 1 && y == IMG_H - 1) begin
      cntExp = cntExp + 8'd1;
      fe.cyc = cyc + 1;
      fe.cnt = cntExp;
      doneQ.push_back(fe);
    end
    #1 check("lb_clken_hi", int'(oLB_CLKEN), 1);
    @(posedge iCLK);
    #1 iDVAL = 1'b0;
  endtask

  task automatic idle(input int n);
    iDVAL = 1'b0;
    #1 check("lb_clken_lo", int'(oLB_CLKEN), 0);
    repeat (n) begin
      @(posedge iCLK);
      #1;
    end
  endtask

  // Raster from (0,0), stopping before linear index stopIdx.
  task automatic fullFrame(input int firstSt, input int stopIdx);
    int st;
    for (int y = 0; y < IMG_H; y++) begin
      for (int x = 0; x < IMG_W; x++) begin
        if (y * IMG_W + x == stopIdx) return;
        if (x == 0 && y == 0) st = firstSt;
        else if (y < 4 || (y == 4 && x == 0)) st = S_FILL;
        else st = S_RUN;
        pix(x, y, st);
        if (x == 0 && y == 0) begin
          check("state_fill", int'(oState), S_FILL);
          check("cnt_hold", int'(oFrameCnt), int'(cntExp));
        end
        if (x == 0 && y == 4) check("state_run", int'(oState), S_RUN);
      end
    end
  endtask

  task automatic fendCheck();
    check("state_fend", int'(oState), S_FEND);
    check("mode_edge_hold", int'(oModeEdge), int'(modeEdgeExp));
    idle(1);
    check("state_idle", int'(oState), S_IDLE);
    check("mode_edge_load", int'(oModeEdge), int'(iEdgeReq));
    check("mode_horiz_load", int'(oModeHoriz), int'(iHorizReq));
    check("frame_cnt", int'(oFrameCnt), int'(cntExp));
    modeEdgeExp = iEdgeReq;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    iRST = 1'b1; iDVAL = 1'b1; iX_Cont = '0; iY_Cont = '0;
    iEdgeReq = 1'b0; iHorizReq = 1'b0;
    @(posedge iCLK);
    #1;
    check("rst_state", int'(oState), S_IDLE);
    check("rst_outputs", int'({oModeEdge, oModeHoriz, oWinValid, oDVAL, oBorder, oFrameDone}), 0);
    check("rst_cnt", int'(oFrameCnt), 0);
    check("rst_lb_clken", int'(oLB_CLKEN), 1);
    iDVAL = 1'b0;
    #1 check("rst_lb_clken_lo", int'(oLB_CLKEN), 0);
    iRST = 1'b0;
    iEdgeReq = 1'b1; iHorizReq = 1'b1;
    idle(4);

    // Frame 1: complete raster with edge mode requested.
    fullFrame(S_IDLE, IMG_W * IMG_H);
    fendCheck();
    idle(3);

    // Frame 2: sparse samples, request withdrawn mid-frame.
    pix(0, 0, S_IDLE);
    pix(4, 2, S_FILL);
    pix(0, 4, S_FILL);
    check("state_run_sparse", int'(oState), S_RUN);
    idle(3);
    pix(2, 6, S_RUN);
    idle(6);
    pix(6, 6, S_RUN);
    iEdgeReq = 1'b0;
    idle(6);
    check("mode_edge_midframe", int'(oModeEdge), 1);
    pix(IMG_W - 1, IMG_H - 1, S_RUN);
    fendCheck();
    idle(3);

    // Frame 3: aborted at row 6 by a new frame start, then completed.
    iEdgeReq = 1'b1;
    fullFrame(S_IDLE, 6 * IMG_W);
    fullFrame(S_RUN, IMG_W * IMG_H);
    fendCheck();
    idle(3);

    // Reset mid-frame with samples in flight, then stray data before (0,0).
    fullFrame(S_IDLE, 6 * IMG_W + 6);
    iRST = 1'b1;
    dvalQ.delete();
    winQ.delete();
    modeEdgeExp = 1'b0;
    cntExp = 8'd0;
    @(posedge iCLK);
    #1;
    check("midrst_state", int'(oState), S_IDLE);
    check("midrst_outputs", int'({oModeEdge, oModeHoriz, oWinValid, oDVAL, oBorder, oFrameDone}), 0);
    check("midrst_cnt", int'(oFrameCnt), 0);
    iRST = 1'b0;
    for (int idx = 6 * IMG_W + 6; idx < IMG_W * IMG_H; idx++) pix(idx % IMG_W, idx / IMG_W, S_IDLE);
    check("stray_state", int'(oState), S_IDLE);
    check("stray_cnt", int'(oFrameCnt), 0);
    idle(3);

    // 256 minimal frames wrap the counter back to zero.
    for (int f = 0; f < 256; f++) begin
      pix(0, 0, S_IDLE);
      pix(0, 4, S_FILL);
      pix(IMG_W - 1, IMG_H - 1, S_RUN);
      idle(1);
      modeEdgeExp = iEdgeReq;
    end
    check("cnt_wrap", int'(oFrameCnt), 0);

    idle(PIPE_LAT + 4);
    check("dval_leftover", dvalQ.size(), 0);
    check("win_leftover", winQ.size(), 0);
    check("done_leftover", doneQ.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
